// File: rtl/opb_select_if.sv
// opb_select_if: operand-B selector bundle (flush, input handshake, sources, forwarding, output handshake)
interface opb_select_if #(parameter int N = 32, parameter int NSRC = 4);
  localparam int SELW = $clog2(NSRC);
  localparam int XW = (NSRC > 2 ? NSRC - 2 : 1) * N;
  logic flush, in_valid, in_ready, out_valid, out_ready, sel_err, fwd_mem_en, fwd_wb_en;
  logic [N-1:0] rdb, extended, fwd_mem_data, fwd_wb_data, selected_opb;
  logic [XW-1:0] src_ext;
  logic [SELW-1:0] opb_selector;
  modport master(
    output flush, in_valid, rdb, extended, src_ext, opb_selector,
           fwd_mem_en, fwd_mem_data, fwd_wb_en, fwd_wb_data, out_ready,
    input  in_ready, out_valid, selected_opb, sel_err
  );
  modport slave(
    input  flush, in_valid, rdb, extended, src_ext, opb_selector,
           fwd_mem_en, fwd_mem_data, fwd_wb_en, fwd_wb_data, out_ready,
    output in_ready, out_valid, selected_opb, sel_err
  );
endinterface

// File: rtl/opb_select_pipe.sv
// opb_select_pipe: registered ALU operand-B selector with forwarding and 2-entry skid buffer.
// Define OPB_FWD_EN to enable the MEM/WB forwarding muxes on source 0.
module opb_select_pipe #(
  parameter int N = 32,
  parameter int NSRC = 4
) (
  input logic clk,
  input logic rst_n,
  opb_select_if.slave b
);
  logic [N-1:0] rdb_f, sel_data;
  logic [N:0] m_q, s_q, new_q;
  logic m_valid, s_valid, sel_err_c, accept, consume;
  int sel, xi;
  always_comb begin
    sel = int'(b.opb_selector);
    sel_err_c = sel >= NSRC;
    xi = (sel_err_c || sel < 2) ? 0 : sel - 2;
    rdb_f = b.rdb;
`ifdef OPB_FWD_EN
    rdb_f = b.fwd_mem_en ? b.fwd_mem_data : b.fwd_wb_en ? b.fwd_wb_data : b.rdb;
`endif
    sel_data = (sel_err_c || sel == 0) ? rdb_f : sel == 1 ? b.extended : b.src_ext[xi*N +: N];
    new_q = {sel_err_c, sel_data};
  end
  assign accept = b.in_valid && !s_valid;
  assign consume = m_valid && b.out_ready;
  // Skid entry only fills while M is held, so M<=S and accept never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q <= '0;
      s_q <= '0;
    end else if (b.flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || consume) begin
      if (s_valid) begin
        m_q <= s_q;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q <= new_q;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_q <= new_q;
      s_valid <= 1'b1;
    end
  end
  assign b.in_ready = !s_valid;
  assign b.out_valid = m_valid;
  assign b.selected_opb = m_q[N-1:0];
  assign b.sel_err = m_q[N];
endmodule

// File: tb/tb_opb_select_pipe.sv
// tb_opb_select_pipe: vectors, directed corner sequences and random traffic against a queue model.
module tb_opb_select_pipe;
`ifdef OPB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  opb_select_if #(.N(32), .NSRC(4)) ba();
  opb_select_if #(.N(32), .NSRC(3)) bb();
  opb_select_pipe #(.N(32), .NSRC(4)) dut_a(.clk(clk), .rst_n(rst_n), .b(ba.slave));
  opb_select_pipe #(.N(32), .NSRC(3)) dut_b(.clk(clk), .rst_n(rst_n), .b(bb.slave));
  int checks = 0, errors = 0;
  logic [32:0] q[$];
  typedef struct {
    logic [1:0] sel;
    logic [31:0] rdb, ext;
    logic [63:0] sx;
    logic fme;
    logic [31:0] fmd;
    logic fwe;
    logic [31:0] fwd;
    logic [31:0] exp_opb;
    logic exp_err;
  } vec_t;
  vec_t tv[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] ref_sel(int nsrc, int sel, logic [31:0] rdb, logic [31:0] ext,
      logic [63:0] sx, logic fme, logic [31:0] fmd, logic fwe, logic [31:0] fwd);
    logic [31:0] r0;
    r0 = (FWD && fme) ? fmd : (FWD && fwe) ? fwd : rdb;
    if (sel >= nsrc) return {1'b1, r0};
    if (sel == 0) return {1'b0, r0};
    if (sel == 1) return {1'b0, ext};
    return {1'b0, sx[(sel-2)*32 +: 32]};
  endfunction

  task automatic check_a();
    chk("out_valid", 64'(ba.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(ba.in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("opb", 64'(ba.selected_opb), 64'(q[0][31:0]));
      chk("sel_err", 64'(ba.sel_err), 64'(q[0][32]));
    end
  endtask

  task automatic cycle();
    logic [32:0] item;
    bit acc, con, fl;
    item = ref_sel(4, int'(ba.opb_selector), ba.rdb, ba.extended, ba.src_ext,
                   ba.fwd_mem_en, ba.fwd_mem_data, ba.fwd_wb_en, ba.fwd_wb_data);
    acc = ba.in_valid && q.size() < 2;
    con = q.size() > 0 && ba.out_ready;
    fl = ba.flush;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(item);
    end
    check_a();
  endtask

  task automatic idle();
    ba.flush = 0; ba.in_valid = 0; ba.out_ready = 1; ba.opb_selector = 0;
    ba.rdb = 0; ba.extended = 0; ba.src_ext = 0;
    ba.fwd_mem_en = 0; ba.fwd_mem_data = 0; ba.fwd_wb_en = 0; ba.fwd_wb_data = 0;
    bb.flush = 0; bb.in_valid = 0; bb.out_ready = 1; bb.opb_selector = 0;
    bb.rdb = 0; bb.extended = 0; bb.src_ext = 0;
    bb.fwd_mem_en = 0; bb.fwd_mem_data = 0; bb.fwd_wb_en = 0; bb.fwd_wb_data = 0;
  endtask

  task automatic push_a(logic [31:0] d);
    ba.in_valid = 1; ba.opb_selector = 0; ba.rdb = d;
    ba.fwd_mem_en = 0; ba.fwd_wb_en = 0;
  endtask

  initial begin
    idle();
    #12;
    chk("rst_out_valid", 64'(ba.out_valid), 64'(0));
    chk("rst_opb", 64'(ba.selected_opb), 64'(0));
    chk("rst_sel_err", 64'(ba.sel_err), 64'(0));
    rst_n = 1;
    cycle();

    tv[0] = '{2'd0, 32'h0000_1234, 32'h0, 64'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_1234, 1'b0};
    tv[1] = '{2'd1, 32'h0000_1111, 32'hFFFF_FFF0, 64'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFF0, 1'b0};
    tv[2] = '{2'd3, 32'h0, 32'h0, 64'hCAFE_0003_BEEF_0002, 1'b0, 32'h0, 1'b0, 32'h0, 32'hCAFE_0003, 1'b0};
    tv[3] = '{2'd2, 32'h0, 32'h0, 64'hCAFE_0003_BEEF_0002, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBEEF_0002, 1'b0};
    tv[4] = '{2'd0, 32'h0000_5678, 32'h0, 64'h0, 1'b1, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002,
              FWD ? 32'hAAAA_0001 : 32'h0000_5678, 1'b0};
    tv[5] = '{2'd0, 32'h0000_9ABC, 32'h0, 64'h0, 1'b0, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002,
              FWD ? 32'hBBBB_0002 : 32'h0000_9ABC, 1'b0};
    tv[6] = '{2'd1, 32'h0000_0001, 32'h1357_2468, 64'h0, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0,
              32'h1357_2468, 1'b0};
    for (int i = 0; i < 7; i++) begin
      ba.in_valid = 1; ba.out_ready = 1; ba.opb_selector = tv[i].sel;
      ba.rdb = tv[i].rdb; ba.extended = tv[i].ext; ba.src_ext = tv[i].sx;
      ba.fwd_mem_en = tv[i].fme; ba.fwd_mem_data = tv[i].fmd;
      ba.fwd_wb_en = tv[i].fwe; ba.fwd_wb_data = tv[i].fwd;
      cycle();
      chk($sformatf("tv%0d_valid", i), 64'(ba.out_valid), 64'(1));
      chk($sformatf("tv%0d_opb", i), 64'(ba.selected_opb), 64'(tv[i].exp_opb));
      chk($sformatf("tv%0d_err", i), 64'(ba.sel_err), 64'(tv[i].exp_err));
    end
    idle();
    cycle();

    ba.out_ready = 0;
    push_a(32'hA);
    cycle();
    push_a(32'hB);
    cycle();
    chk("stall_in_ready", 64'(ba.in_ready), 64'(0));
    push_a(32'hC);
    cycle();
    chk("stall_hold_a", 64'(ba.selected_opb), 64'(32'hA));
    ba.out_ready = 1;
    cycle();
    chk("drain_b", 64'(ba.selected_opb), 64'(32'hB));
    cycle();
    chk("drain_c", 64'(ba.selected_opb), 64'(32'hC));
    idle();
    cycle();
    chk("drain_empty", 64'(ba.out_valid), 64'(0));

    ba.out_ready = 0;
    push_a(32'h11);
    cycle();
    push_a(32'h22);
    cycle();
    push_a(32'hD);
    ba.flush = 1;
    cycle();
    chk("flush_valid", 64'(ba.out_valid), 64'(0));
    chk("flush_in_ready", 64'(ba.in_ready), 64'(1));
    idle();
    cycle();
    chk("flush_nothing", 64'(ba.out_valid), 64'(0));

    bb.in_valid = 1; bb.opb_selector = 2'd3; bb.rdb = 32'h5555;
    cycle();
    chk("n3_err_opb", 64'(bb.selected_opb), 64'(32'h5555));
    chk("n3_err_flag", 64'(bb.sel_err), 64'(1));
    bb.opb_selector = 2'd2; bb.src_ext = 32'h7777;
    cycle();
    chk("n3_ext_opb", 64'(bb.selected_opb), 64'(32'h7777));
    chk("n3_ext_flag", 64'(bb.sel_err), 64'(0));
    bb.opb_selector = 2'd3; bb.fwd_mem_en = 1; bb.fwd_mem_data = 32'h9999;
    cycle();
    chk("n3_err_fwd", 64'(bb.selected_opb), 64'(FWD ? 32'h9999 : 32'h5555));
    idle();
    cycle();

    ba.out_ready = 0;
    push_a(32'h33);
    cycle();
    push_a(32'h44);
    cycle();
    #2 rst_n = 0;
    #1;
    q.delete();
    chk("rst_mid_valid", 64'(ba.out_valid), 64'(0));
    chk("rst_mid_in_ready", 64'(ba.in_ready), 64'(1));
    chk("rst_mid_opb", 64'(ba.selected_opb), 64'(0));
    chk("rst_mid_b_valid", 64'(bb.out_valid), 64'(0));
    #2 rst_n = 1;
    idle();
    cycle();

    for (int i = 0; i < 500; i++) begin
      ba.in_valid = $urandom_range(0, 3) != 0;
      ba.out_ready = $urandom_range(0, 2) != 0;
      ba.flush = $urandom_range(0, 15) == 0;
      ba.opb_selector = 2'($urandom_range(0, 3));
      ba.rdb = $urandom; ba.extended = $urandom; ba.src_ext = {$urandom, $urandom};
      ba.fwd_mem_en = 1'($urandom); ba.fwd_mem_data = $urandom;
      ba.fwd_wb_en = 1'($urandom); ba.fwd_wb_data = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
